mux8_rr_scheduler: RTL and testbench
====================================

# mux8_rr_scheduler

Round-robin scheduler that shares the 8:1 bit multiplexer between eight requesters. It arbitrates `io_req`, drives the mux select lines `io_s0`/`io_s1`/`io_s2`, and bounds each grant's tenure. It also registers the selected data bit so the winning requester receives it with a fixed one-cycle latency. It sits directly in front of the 8:1 mux instance and owns its select inputs.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive grant cycles while another requester is waiting. Legal range 1..15.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- `io_req` input 8: request per requester; bit i = requester i.
- `io_in` input 8: data bits; bit i belongs to requester i (same bit order as the mux inputs).
- `io_grant` output 8: registered one-hot grant, all-zero when idle.
- `io_s0`, `io_s1`, `io_s2` output 1 each: select bits of the granted index (s0 = LSB), registered.
- `io_busy` output 1: a grant is active this cycle.
- `io_out` output 1: registered copy of `io_in[granted index]`.
- `io_out_valid` output 1: `io_out` holds a sample taken during a grant cycle.

## Operation
- State
  - Two-state FSM, IDLE and HOLD.
  - 3-bit round-robin pointer `ptr`: lowest-priority-next start index.
  - 3-bit current index `cur`.
  - 4-bit tenure counter `cnt`.
- Reset (`reset` = 0, immediate, asynchronous)
  - FSM = IDLE; `ptr` = 0, `cur` = 0, `cnt` = 0.
  - Outputs: `io_grant` = 0, `io_s0`/`io_s1`/`io_s2` = 0, `io_busy` = 0, `io_out` = 0, `io_out_valid` = 0.
  - Reset mid-grant drops the grant in that same cycle. No state survives reset.
- Pick function: the first set bit of `io_req` searching upward from `ptr`, wrapping 7->0.
- IDLE
  - If `io_req` != 0: go to HOLD; `cur` = pick; `cnt` = 1.
  - Otherwise stay in IDLE.
- HOLD: release occurs when either condition holds.
  - (a) `io_req[cur]` = 0.
  - (b) `cnt` = `HOLD_MAX` and some other `io_req` bit is set.
- On release
  - `ptr` = `cur`+1 (mod 8).
  - The pick is recomputed from the new `ptr`, with `io_req[cur]` masked in case (b).
  - If a winner exists, switch `cur` to it with `cnt` = 1 and no idle cycle in between. Otherwise go to IDLE.
- No release: `cnt` increments, saturating at `HOLD_MAX`. A sole requester therefore holds indefinitely.
- Select and grant outputs
  - `{io_s2,io_s1,io_s0}` = `cur` while in HOLD; held at the last value in IDLE.
  - `io_grant` = one-hot(`cur`) in HOLD, 0 in IDLE.
  - `io_busy` = (state == HOLD).
- Data sampling
  - Each cycle: `io_out` <= `io_in[cur]` if in HOLD, else keep the previous value.
  - `io_out_valid` <= `io_busy`.

## Timing
- Request to grant: `io_req` sampled at edge k; `io_grant`/`io_s*` valid after edge k (1 cycle). Requests are not combinationally forwarded.
- Grant to data: `io_out` for grant cycle n is valid after edge n+1. `io_out_valid` marks it.
- Handover: switching requesters costs zero dead cycles; back-to-back grants are contiguous.
- Dropping a request: when `io_req[cur]` falls before edge k, the grant is removed or changed after edge k. The requester may see one extra grant cycle, which it must ignore while its request is low.
- Simultaneous events
  - A new request arriving in the same cycle as a release is considered in that release's pick.
  - Requests asserting mid-tenure wait for release.
- Fairness: any continuously asserting requester is granted within 7*`HOLD_MAX` cycles.

## Test plan
- Reset behaviour: drive `reset`=0 mid-grant with `io_req`=0xFF -> all outputs 0 immediately. After release with `io_req`=0x01, `io_grant`=0x01 one cycle later.
- Single requester: `io_req`=0x20 held for 20 cycles -> `io_grant`=0x20, `{s2,s1,s0}`=101 throughout, no preemption. With `io_in`=0x20, `io_out`=1 and `io_out_valid`=1 from the second grant cycle.
- Round-robin with `HOLD_MAX`=4: `io_req`=0xFF constantly -> grants 0,1,...,7,0 each for exactly 4 cycles, contiguous.
- Early release: `io_req`=0x06; requester 1 drops after 2 cycles -> grant moves to index 2 with no gap, and `ptr` advances so the next pick after 2 starts at 3.
- Wrap-around: `ptr` at 7, `io_req`=0x81 -> index 7 granted first, then 0. With `io_in` toggling, `io_out` tracks `io_in[cur]` delayed by 1 cycle.
- Simultaneous drop and arrival: requester 3 drops while requester 5 rises in the same cycle, with idle elsewhere -> after the edge `io_grant`=0x20 with no IDLE cycle.

Source files
------------

// File: rtl/mux8_rr_scheduler.sv
// rtl/mux8_rr_scheduler.sv - round-robin scheduler owning the select lines of an 8:1 bit mux
// Bounds each grant's tenure to HOLD_MAX cycles while others wait and registers the selected data bit.
module mux8_rr_scheduler #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] io_req,
    input  logic [7:0] io_in,
    output logic [7:0] io_grant,
    output logic       io_s0,
    output logic       io_s1,
    output logic       io_s2,
    output logic       io_busy,
    output logic       io_out,
    output logic       io_out_valid
);

    localparam logic       IDLE   = 1'b0;
    localparam logic       HOLD   = 1'b1;
    localparam logic [3:0] HMAX_C = 4'(HOLD_MAX);

    logic       state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] cur_q, cur_d;
    logic [3:0] cnt_q, cnt_d;
    logic       out_q, out_d;
    logic       out_valid_q;

    logic [7:0] cur_oh;
    logic [7:0] others;
    logic [2:0] ptr_next;
    logic [3:0] idle_pick;
    logic [3:0] rel_pick;
    logic       rel;

    // Returns {found, index} of the first set bit at or above start, wrapping 7->0.
    function automatic logic [3:0] pick_fn(input logic [7:0] req, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = start + i[2:0];
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign cur_oh    = 8'b1 << cur_q;
    // Masking cur on every release is harmless: on a drop its request bit is already 0.
    assign others    = io_req & ~cur_oh;
    assign ptr_next  = cur_q + 3'd1;
    assign idle_pick = pick_fn(io_req, ptr_q);
    assign rel_pick  = pick_fn(others, ptr_next);
    assign rel       = !io_req[cur_q] || ((cnt_q == HMAX_C) && (|others));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (state_q == IDLE) begin
            if (idle_pick[3]) begin
                state_d = HOLD;
                cur_d   = idle_pick[2:0];
                cnt_d   = 4'd1;
            end
        end else begin
            out_d = io_in[cur_q];
            if (rel) begin
                ptr_d = ptr_next;
                if (rel_pick[3]) begin
                    cur_d = rel_pick[2:0];
                    cnt_d = 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end else if (cnt_q != HMAX_C) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            cur_q       <= 3'd0;
            cnt_q       <= 4'd0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= (state_q == HOLD);
        end
    end

    // cur_q is only rewritten on a new grant, so the selects naturally hold their last value in IDLE.
    assign io_busy      = (state_q == HOLD);
    assign io_grant     = io_busy ? cur_oh : 8'd0;
    assign io_s0        = cur_q[0];
    assign io_s1        = cur_q[1];
    assign io_s2        = cur_q[2];
    assign io_out       = out_q;
    assign io_out_valid = out_valid_q;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// tb/tb_mux8_rr_scheduler.sv - directed self-checking bench for mux8_rr_scheduler
module tb_mux8_rr_scheduler;

    logic       clock;
    logic       reset;
    logic [7:0] io_req;
    logic [7:0] io_in;
    logic [7:0] io_grant;
    logic       io_s0, io_s1, io_s2;
    logic       io_busy;
    logic       io_out;
    logic       io_out_valid;

    int tests;
    int failures;

    mux8_rr_scheduler #(.HOLD_MAX(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .io_req      (io_req),
        .io_in       (io_in),
        .io_grant    (io_grant),
        .io_s0       (io_s0),
        .io_s1       (io_s1),
        .io_s2       (io_s2),
        .io_busy     (io_busy),
        .io_out      (io_out),
        .io_out_valid(io_out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] in_v;
        logic [2:0] cur_exp;
        logic [2:0] nxt_exp;

        tests    = 0;
        failures = 0;
        reset    = 1'b0;
        io_req   = 8'h00;
        io_in    = 8'h00;
        step();
        step();
        check("rst_grant", {24'd0, io_grant}, 32'h00);
        check("rst_sel", {29'd0, io_s2, io_s1, io_s0}, 32'd0);
        check("rst_busy", {31'd0, io_busy}, 32'd0);
        check("rst_out", {31'd0, io_out}, 32'd0);
        check("rst_valid", {31'd0, io_out_valid}, 32'd0);

        // Single requester 5 holds with no preemption
        reset  = 1'b1;
        io_req = 8'h20;
        io_in  = 8'h20;
        for (int i = 0; i < 20; i++) begin
            step();
            check("single_grant", {24'd0, io_grant}, 32'h20);
            check("single_sel", {29'd0, io_s2, io_s1, io_s0}, 32'd5);
            check("single_out", {31'd0, io_out}, (i >= 1) ? 32'd1 : 32'd0);
            check("single_valid", {31'd0, io_out_valid}, (i >= 1) ? 32'd1 : 32'd0);
        end
        io_req = 8'h00;
        step();
        check("idle_grant", {24'd0, io_grant}, 32'h00);
        check("idle_busy", {31'd0, io_busy}, 32'd0);
        check("idle_sel_held", {29'd0, io_s2, io_s1, io_s0}, 32'd5);
        check("idle_valid_tail", {31'd0, io_out_valid}, 32'd1);
        step();
        check("idle_valid_off", {31'd0, io_out_valid}, 32'd0);
        check("idle_out_kept", {31'd0, io_out}, 32'd1);

        // Pointer is now 6; full request picks 6, then reset mid-grant
        io_req = 8'hFF;
        io_in  = 8'hFF;
        step();
        check("ptr6_grant", {24'd0, io_grant}, 32'h40);
        step();
        check("pre_rst_out", {31'd0, io_out}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_grant", {24'd0, io_grant}, 32'h00);
        check("async_sel", {29'd0, io_s2, io_s1, io_s0}, 32'd0);
        check("async_busy", {31'd0, io_busy}, 32'd0);
        check("async_out", {31'd0, io_out}, 32'd0);
        check("async_valid", {31'd0, io_out_valid}, 32'd0);
        io_req = 8'h01;
        #1;
        reset = 1'b1;
        step();
        check("post_rst_grant", {24'd0, io_grant}, 32'h01);

        // Round robin, 4 cycles each, 0..7 then 0 again
        io_req = 8'hFF;
        for (int j = 1; j < 36; j++) begin
            step();
            check("rr_grant", {24'd0, io_grant}, 32'd1 << ((j / 4) % 8));
            check("rr_busy", {31'd0, io_busy}, 32'd1);
        end

        // Early release: 1 for two cycles, then 2, then pointer continues at 3
        io_req = 8'h06;
        step();
        check("early_g1a", {24'd0, io_grant}, 32'h02);
        step();
        check("early_g1b", {24'd0, io_grant}, 32'h02);
        io_req = 8'h04;
        step();
        check("early_g2", {24'd0, io_grant}, 32'h04);
        io_req = 8'h0A;
        step();
        check("early_ptr3", {24'd0, io_grant}, 32'h08);

        // Requester 3 drops while 5 rises in the same cycle
        io_req = 8'h20;
        step();
        check("simul_grant", {24'd0, io_grant}, 32'h20);
        check("simul_busy", {31'd0, io_busy}, 32'd1);

        // Move pointer to 7, then wrap 7 -> 0 with toggling data
        io_req = 8'h40;
        step();
        check("wrap_g6", {24'd0, io_grant}, 32'h40);
        io_req = 8'h81;
        io_in  = 8'h00;
        step();
        check("wrap_g7", {24'd0, io_grant}, 32'h80);
        check("wrap_sel7", {29'd0, io_s2, io_s1, io_s0}, 32'd7);
        for (int k = 0; k < 5; k++) begin
            cur_exp = (k < 4) ? 3'd7 : 3'd0;
            nxt_exp = (k + 1 < 4) ? 3'd7 : 3'd0;
            in_v    = (k % 2 == 0) ? 8'h80 : 8'h01;
            io_in   = in_v;
            step();
            check("wrap_grant", {24'd0, io_grant}, 32'd1 << nxt_exp);
            check("wrap_out", {31'd0, io_out}, {31'd0, in_v[cur_exp]});
            check("wrap_valid", {31'd0, io_out_valid}, 32'd1);
        end

        io_req = 8'h00;
        step();
        check("final_busy", {31'd0, io_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
